// File: rtl/array_pair_compare.sv
// Collects DEPTH element pairs into arrays A and B, compares them one index per
// cycle, and presents match / mismatch count / first mismatch index on a valid/ready port.
module array_pair_compare #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 1,
    parameter int IDXW  = $clog2(DEPTH),
    parameter int CNTW  = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_a_i,
    input  logic [WIDTH-1:0] in_b_i,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic             res_match_o,
    output logic [CNTW-1:0]  res_mismatch_cnt_o,
    output logic [IDXW-1:0]  res_first_idx_o,
    output logic             busy_o
);

    typedef enum logic [1:0] {LOAD, COMPARE, REPORT} state_t;

    state_t           state_q;
    logic [IDXW-1:0]  idx_q;
    logic [WIDTH-1:0] a_q [DEPTH];
    logic [WIDTH-1:0] b_q [DEPTH];
    logic [CNTW-1:0]  cnt_q;
    logic [IDXW-1:0]  first_q;
    logic             found_q;
    logic             done_q;
    logic             in_ready_q;
    logic             res_valid_q;
    logic             res_match_q;
    logic [CNTW-1:0]  res_cnt_q;
    logic [IDXW-1:0]  res_first_q;
    logic             busy_q;
    logic             mism_d;
    logic             last_d;

    assign mism_d = (a_q[idx_q] != b_q[idx_q]);
    assign last_d = (idx_q == IDXW'(DEPTH - 1));

    // done_q marks that every index has been compared; the following cycle
    // registers the result, giving the fixed DEPTH+1 latency to res_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= LOAD;
            idx_q       <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                a_q[i] <= '0;
                b_q[i] <= '0;
            end
            cnt_q       <= '0;
            first_q     <= '0;
            found_q     <= 1'b0;
            done_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            res_valid_q <= 1'b0;
            res_match_q <= 1'b0;
            res_cnt_q   <= '0;
            res_first_q <= '0;
            busy_q      <= 1'b0;
        end else if (clear_i) begin
            state_q     <= LOAD;
            idx_q       <= '0;
            cnt_q       <= '0;
            first_q     <= '0;
            found_q     <= 1'b0;
            done_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            res_valid_q <= 1'b0;
            res_match_q <= 1'b0;
            res_cnt_q   <= '0;
            res_first_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                LOAD: begin
                    in_ready_q <= 1'b1;
                    if (in_valid_i && in_ready_q) begin
                        a_q[idx_q] <= in_a_i;
                        b_q[idx_q] <= in_b_i;
                        if (last_d) begin
                            idx_q      <= '0;
                            state_q    <= COMPARE;
                            in_ready_q <= 1'b0;
                            busy_q     <= 1'b1;
                            cnt_q      <= '0;
                            first_q    <= '0;
                            found_q    <= 1'b0;
                            done_q     <= 1'b0;
                        end else begin
                            idx_q <= idx_q + IDXW'(1);
                        end
                    end
                end
                COMPARE: begin
                    if (!done_q) begin
                        if (mism_d) begin
                            cnt_q <= cnt_q + CNTW'(1);
                            if (!found_q) begin
                                first_q <= idx_q;
                                found_q <= 1'b1;
                            end
                        end
                        if (last_d) begin
                            idx_q  <= '0;
                            done_q <= 1'b1;
                        end else begin
                            idx_q <= idx_q + IDXW'(1);
                        end
                    end else begin
                        state_q     <= REPORT;
                        done_q      <= 1'b0;
                        res_valid_q <= 1'b1;
                        res_match_q <= (cnt_q == '0);
                        res_cnt_q   <= cnt_q;
                        res_first_q <= first_q;
                    end
                end
                REPORT: begin
                    if (res_ready_i) begin
                        state_q     <= LOAD;
                        res_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        cnt_q       <= '0;
                        first_q     <= '0;
                        found_q     <= 1'b0;
                    end
                end
                default: state_q <= LOAD;
            endcase
        end
    end

    assign in_ready_o         = in_ready_q;
    assign res_valid_o        = res_valid_q;
    assign res_match_o        = res_match_q;
    assign res_mismatch_cnt_o = res_cnt_q;
    assign res_first_idx_o    = res_first_q;
    assign busy_o             = busy_q;

endmodule
